// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the signals around the shared ALU arbiter:
//   - two requester channels (reqN_valid/ready, reqN_op1/op2/ctrl)
//   - two response channels (rspN_valid/ready, rspN_result/zero/err)
//   - the ALU side (alu_input1/2, alu_control out; alu_result/alu_zero in)
// Modports:
//   slave  : the arbiter itself
//   master : everything around it (requesters, response consumers, the ALU)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
);
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [WIDTH-1:0]  req0_op1, req1_op1;
  logic [WIDTH-1:0]  req0_op2, req1_op2;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;

  logic [WIDTH-1:0]  alu_input1, alu_input2;
  logic [CTRL_W-1:0] alu_control;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;

  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0]  rsp0_result, rsp1_result;
  logic              rsp0_zero, rsp1_zero;
  logic              rsp0_err, rsp1_err;

  modport slave (
    input  req0_valid, req1_valid, req0_op1, req1_op1, req0_op2, req1_op2,
           req0_ctrl, req1_ctrl, alu_result, alu_zero, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, alu_input1, alu_input2, alu_control,
           rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
           rsp0_zero, rsp1_zero, rsp0_err, rsp1_err
  );

  modport master (
    output req0_valid, req1_valid, req0_op1, req1_op1, req0_op2, req1_op2,
           req0_ctrl, req1_ctrl, alu_result, alu_zero, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, alu_input1, alu_input2, alu_control,
           rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
           rsp0_zero, rsp1_zero, rsp0_err, rsp1_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. A round-robin arbiter
// accepts one operation in IDLE, drives the latched operands to the ALU for a
// single EXEC cycle, then presents the registered result/zero/err on the
// owning requester's response channel (RESP) until it is consumed.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_arbiter_if.slave (request, response and ALU signals)
// WIDTH/CTRL_W must match the parameters of the connected interface.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q;
  logic              last_grant_q;   // requester served most recently
  logic              owner_q;        // requester owning the in-flight op
  logic [WIDTH-1:0]  alu_in1_q, alu_in2_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic [1:0]        rsp_valid_q, rsp_zero_q, rsp_err_q;
  logic [WIDTH-1:0]  rsp_result_q [2];

  logic grant;
  logic req0_ready, req1_ready, accept;
  logic ctrl_illegal;
  logic owner_rsp_ready;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = bus.req1_valid;          // lone requester wins
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;         // contention: the one not served last
    end
    // Ready is gated by rst_n so nothing is accepted while reset is held.
    req0_ready = rst_n && (state_q == IDLE) && bus.req0_valid && !grant;
    req1_ready = rst_n && (state_q == IDLE) && bus.req1_valid &&  grant;
    accept     = req0_ready || req1_ready;
  end

  // Legal codes are 0..8 and 13; checked on the latched control the ALU sees.
  assign ctrl_illegal = (alu_ctrl_q > CTRL_W'(8)) && (alu_ctrl_q != CTRL_W'(13));
  assign owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;          // makes requester 0 win the first contention
      owner_q      <= 1'b0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_ctrl_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_zero_q   <= '0;
      rsp_err_q    <= '0;
      // NOTE: the result pair is two ordinary registers, not a RAM, so it is
      // reset like any other register to give defined outputs out of reset.
      for (int i = 0; i < 2; i++) rsp_result_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_in1_q  <= grant ? bus.req1_op1  : bus.req0_op1;
            alu_in2_q  <= grant ? bus.req1_op2  : bus.req0_op2;
            alu_ctrl_q <= grant ? bus.req1_ctrl : bus.req0_ctrl;
            owner_q    <= grant;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          // Illegal codes return a clean zero result rather than ALU garbage.
          rsp_result_q[owner_q] <= ctrl_illegal ? '0 : bus.alu_result;
          rsp_zero_q[owner_q]   <= ctrl_illegal | bus.alu_zero;
          rsp_err_q[owner_q]    <= ctrl_illegal;
          rsp_valid_q[owner_q]  <= 1'b1;
          state_q               <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            rsp_valid_q[owner_q] <= 1'b0;
            last_grant_q         <= owner_q;
            state_q              <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = req0_ready;
  assign bus.req1_ready  = req1_ready;
  assign bus.alu_input1  = alu_in1_q;
  assign bus.alu_input2  = alu_in2_q;
  assign bus.alu_control = alu_ctrl_q;
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp0_result = rsp_result_q[0];
  assign bus.rsp1_result = rsp_result_q[1];
  assign bus.rsp0_zero   = rsp_zero_q[0];
  assign bus.rsp1_zero   = rsp_zero_q[1];
  assign bus.rsp0_err    = rsp_err_q[0];
  assign bus.rsp1_err    = rsp_err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter. A small reference ALU closes the loop on the
// ALU side; each scenario task drives requests and compares the outputs
// against hand-computed values. Inputs change 1 ns after the rising edge and
// outputs are sampled there too, away from the edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int WIDTH  = 64;
  localparam int CTRL_W = 4;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  alu_arbiter_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU; unsupported codes yield a non-zero junk value.
  function automatic logic [WIDTH-1:0] alu_model(input logic [CTRL_W-1:0] c,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a << b[5:0];
      4'd5:    return a >> b[5:0];
      4'd6:    return a - b;
      4'd7:    return {63'd0, $signed(a) < $signed(b)};
      4'd8:    return ~(a | b);
      4'd13:   return $signed(a) >>> b[5:0];
      default: return 64'hDEAD_BEEF_0000_0001;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.alu_control, bus.alu_input1, bus.alu_input2);
  assign bus.alu_zero   = (bus.alu_result == '0);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
    bus.req0_op1 = '0; bus.req0_op2 = '0; bus.req0_ctrl = '0;
    bus.req1_op1 = '0; bus.req1_op2 = '0; bus.req1_ctrl = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    #3;
    checks++; if (bus.req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready got=%b exp=0", bus.req0_ready); end
    checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", {bus.rsp0_valid, bus.rsp1_valid}); end
    checks++; if ({bus.alu_input1, bus.alu_input2, bus.alu_control} !== '0) begin failures++; $display("FAIL reset_alu got=%h/%h/%h exp=0", bus.alu_input1, bus.alu_input2, bus.alu_control); end
    checks++; if ({bus.rsp0_result, bus.rsp1_result, bus.rsp0_zero, bus.rsp1_zero, bus.rsp0_err, bus.rsp1_err} !== '0) begin failures++; $display("FAIL reset_rsp_regs got=%h %h z=%b%b e=%b%b exp=0", bus.rsp0_result, bus.rsp1_result, bus.rsp0_zero, bus.rsp1_zero, bus.rsp0_err, bus.rsp1_err); end
    bus.req0_valid = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Test 1: 5 + 7 on requester 0, response two edges after accept.
  task automatic test_add;
    bus.req0_valid = 1'b1; bus.req0_ctrl = 4'd2; bus.req0_op1 = 64'd5; bus.req0_op2 = 64'd7;
    bus.rsp0_ready = 1'b1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL add_ready got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
    tick;  // accept edge
    bus.req0_valid = 1'b0;
    checks++; if (bus.req0_ready !== 1'b0) begin failures++; $display("FAIL add_ready_exec got=%b exp=0", bus.req0_ready); end
    checks++; if ({bus.alu_input1, bus.alu_input2, bus.alu_control} !== {64'd5, 64'd7, 4'd2}) begin failures++; $display("FAIL add_alu_drive got=%h/%h/%h exp=5/7/2", bus.alu_input1, bus.alu_input2, bus.alu_control); end
    checks++; if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid got=%b exp=0", bus.rsp0_valid); end
    tick;
    checks++; if ({bus.rsp0_valid, bus.rsp0_result, bus.rsp0_zero, bus.rsp0_err} !== {1'b1, 64'd12, 1'b0, 1'b0}) begin failures++; $display("FAIL add_rsp got v=%b r=%0d z=%b e=%b exp v=1 r=12 z=0 e=0", bus.rsp0_valid, bus.rsp0_result, bus.rsp0_zero, bus.rsp0_err); end
    tick;
    checks++; if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL add_valid_drop got=%b exp=0", bus.rsp0_valid); end
    bus.rsp0_ready = 1'b0;
  endtask

  // Test 2: 9 - 9 on requester 1 yields zero; channel 0 never fires.
  task automatic test_sub_zero;
    bus.req1_valid = 1'b1; bus.req1_ctrl = 4'd6; bus.req1_op1 = 64'd9; bus.req1_op2 = 64'd9;
    bus.rsp1_ready = 1'b1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin failures++; $display("FAIL sub_ready got=%b exp=01", {bus.req0_ready, bus.req1_ready}); end
    tick;
    bus.req1_valid = 1'b0;
    tick;
    checks++; if ({bus.rsp1_valid, bus.rsp1_result, bus.rsp1_zero, bus.rsp1_err} !== {1'b1, 64'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL sub_rsp got v=%b r=%0d z=%b e=%b exp v=1 r=0 z=1 e=0", bus.rsp1_valid, bus.rsp1_result, bus.rsp1_zero, bus.rsp1_err); end
    checks++; if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL sub_rsp0_quiet got=%b exp=0", bus.rsp0_valid); end
    tick;
    checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin failures++; $display("FAIL sub_valid_drop got=%b exp=00", {bus.rsp0_valid, bus.rsp1_valid}); end
  endtask

  // Test 3: both requesters held valid; grants alternate 0,1,0,1, 3 cycles each.
  task automatic test_back_to_back;
    logic [WIDTH-1:0] exp_res;
    bus.req0_valid = 1'b1; bus.req0_ctrl = 4'd2; bus.req0_op1 = 64'd100; bus.req0_op2 = 64'd1;
    bus.req1_valid = 1'b1; bus.req1_ctrl = 4'd6; bus.req1_op1 = 64'd50;  bus.req1_op2 = 64'd8;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_res = (k % 2 == 0) ? 64'd101 : 64'd42;
      checks++; if ({bus.req0_ready, bus.req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL b2b_grant op=%0d got=%b exp=%b", k, {bus.req0_ready, bus.req1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      tick; tick;
      checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL b2b_channel op=%0d got=%b exp=%b", k, {bus.rsp0_valid, bus.rsp1_valid}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      checks++; if (((k % 2 == 0) ? bus.rsp0_result : bus.rsp1_result) !== exp_res) begin failures++; $display("FAIL b2b_result op=%0d got=%0d exp=%0d", k, (k % 2 == 0) ? bus.rsp0_result : bus.rsp1_result, exp_res); end
      tick;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  // Test 4: arithmetic shift held under back-pressure; req1 waits.
  task automatic test_hold_sra;
    bus.req0_valid = 1'b1; bus.req0_ctrl = 4'd13; bus.req0_op1 = 64'h8000_0000_0000_0000; bus.req0_op2 = 64'd4;
    bus.req1_valid = 1'b1; bus.req1_ctrl = 4'd2;  bus.req1_op1 = 64'd3; bus.req1_op2 = 64'd4;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL hold_grant got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
    tick;
    bus.req0_valid = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.rsp0_valid, bus.rsp0_result, bus.req1_ready} !== {1'b1, 64'hF800_0000_0000_0000, 1'b0}) begin failures++; $display("FAIL hold_stable cyc=%0d got v=%b r=%h rdy1=%b exp v=1 r=f800000000000000 rdy1=0", i, bus.rsp0_valid, bus.rsp0_result, bus.req1_ready); end
      tick;
    end
    bus.rsp0_ready = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL hold_handshake_ready got=%b exp=0", bus.req1_ready); end
    tick;
    checks++; if ({bus.rsp0_valid, bus.req1_ready} !== 2'b01) begin failures++; $display("FAIL hold_release got v0=%b rdy1=%b exp v0=0 rdy1=1", bus.rsp0_valid, bus.req1_ready); end
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
    tick;
    bus.req1_valid = 1'b0;
    tick;
    checks++; if ({bus.rsp1_valid, bus.rsp1_result, bus.rsp1_err} !== {1'b1, 64'd7, 1'b0}) begin failures++; $display("FAIL hold_req1_rsp got v=%b r=%0d e=%b exp v=1 r=7 e=0", bus.rsp1_valid, bus.rsp1_result, bus.rsp1_err); end
    tick;
  endtask

  // Test 5: illegal code 1010 forces err/zero; next legal op clears err.
  task automatic test_illegal;
    bus.req1_valid = 1'b1; bus.req1_ctrl = 4'd10; bus.req1_op1 = 64'd3; bus.req1_op2 = 64'd4;
    bus.rsp1_ready = 1'b1;
    tick;
    bus.req1_valid = 1'b0;
    tick;
    checks++; if ({bus.rsp1_valid, bus.rsp1_err, bus.rsp1_result, bus.rsp1_zero} !== {1'b1, 1'b1, 64'd0, 1'b1}) begin failures++; $display("FAIL illegal_rsp got v=%b e=%b r=%h z=%b exp v=1 e=1 r=0 z=1", bus.rsp1_valid, bus.rsp1_err, bus.rsp1_result, bus.rsp1_zero); end
    tick;
    bus.req1_valid = 1'b1; bus.req1_ctrl = 4'd2;
    tick;
    bus.req1_valid = 1'b0;
    tick;
    checks++; if ({bus.rsp1_valid, bus.rsp1_err, bus.rsp1_result, bus.rsp1_zero} !== {1'b1, 1'b0, 64'd7, 1'b0}) begin failures++; $display("FAIL legal_after_illegal got v=%b e=%b r=%0d z=%b exp v=1 e=0 r=7 z=0", bus.rsp1_valid, bus.rsp1_err, bus.rsp1_result, bus.rsp1_zero); end
    tick;
  endtask

  // Test 6: async reset during EXEC discards the op and restores last_grant=1.
  task automatic test_reset_mid_exec;
    // Serve requester 0 first so the pre-reset last_grant is 0.
    bus.req0_valid = 1'b1; bus.req0_ctrl = 4'd2; bus.req0_op1 = 64'd1; bus.req0_op2 = 64'd1;
    bus.rsp0_ready = 1'b1;
    tick;
    bus.req0_valid = 1'b0;
    tick; tick;
    bus.req1_valid = 1'b1; bus.req1_ctrl = 4'd3; bus.req1_op1 = 64'h55; bus.req1_op2 = 64'hF0;
    tick;  // requester 1 now in EXEC
    bus.req1_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin failures++; $display("FAIL midrst_valid got=%b exp=00", {bus.rsp0_valid, bus.rsp1_valid}); end
    checks++; if ({bus.alu_input1, bus.alu_input2, bus.alu_control} !== '0) begin failures++; $display("FAIL midrst_alu got=%h/%h/%h exp=0", bus.alu_input1, bus.alu_input2, bus.alu_control); end
    tick;
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op1 = 64'd20; bus.req0_op2 = 64'd22;
    bus.req1_valid = 1'b1; bus.req1_ctrl = 4'd2; bus.req1_op1 = 64'd1; bus.req1_op2 = 64'd2;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL midrst_first_grant got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
    tick;
    bus.req0_valid = 1'b0;
    tick;
    checks++; if ({bus.rsp0_valid, bus.rsp0_result, bus.rsp1_valid} !== {1'b1, 64'd42, 1'b0}) begin failures++; $display("FAIL midrst_after got v0=%b r0=%0d v1=%b exp v0=1 r0=42 v1=0", bus.rsp0_valid, bus.rsp0_result, bus.rsp1_valid); end
    tick;
    tick;
    bus.req1_valid = 1'b0;
    tick;
    checks++; if ({bus.rsp1_valid, bus.rsp1_result} !== {1'b1, 64'd3}) begin failures++; $display("FAIL midrst_req1 got v1=%b r1=%0d exp v1=1 r1=3", bus.rsp1_valid, bus.rsp1_result); end
    tick;
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_zero;
    test_back_to_back;
    test_hold_sra;
    test_illegal;
    test_reset_mid_exec;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 64-bit ALU between two requesters (e.g. the integer pipe and the address/branch unit) using valid/ready handshakes and round-robin arbitration. Each accepted operation is latched, driven to the ALU for one cycle, and its registered result and zero flag are returned on the owning requester's response channel. One operation is in flight at a time. Unsupported control codes are flagged as errors.

Parameters:
- WIDTH, 64, operand/result width.
- CTRL_W, 4, ALU control width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid / req1_valid  input  1  request valid.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_op1 / req1_op1  input  WIDTH  first operand.
- req0_op2 / req1_op2  input  WIDTH  second operand.
- req0_ctrl / req1_ctrl  input  CTRL_W  ALU control code.
- alu_input1  output  WIDTH  to ALU first operand.
- alu_input2  output  WIDTH  to ALU second operand.
- alu_control  output  CTRL_W  to ALU control.
- alu_result  input  WIDTH  from ALU (combinational).
- alu_zero  input  1  from ALU zero flag.
- rsp0_valid / rsp1_valid  output  1  response valid.
- rsp0_ready / rsp1_ready  input  1  response consumed.
- rsp0_result / rsp1_result  output  WIDTH  registered result.
- rsp0_zero / rsp1_zero  output  1  registered zero flag.
- rsp0_err / rsp1_err  output  1  illegal control code.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. Under reset: state=IDLE, last_grant=1, all alu_* regs=0, rspN_valid=0, rspN_result=0, rspN_zero=0, rspN_err=0, reqN_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - grant = the only valid requester.
  - If both are valid, grant = the requester != last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. This is combinational from valid; at most one ready is high.
- IDLE, on accept edge: latch op1/op2/ctrl into the alu_input1/alu_input2/alu_control regs, record owner, and go to EXEC. With no valid request, stay in IDLE.
- EXEC (exactly one cycle): the ALU sees the latched operands. At the next edge:
  - capture rsp_result = alu_result and rsp_zero = alu_zero into the owner's response regs;
  - set rsp_err = ctrl not in {0..8, 13};
  - if err, force result=0 and zero=1;
  - set rsp<owner>_valid=1 and go to RESP.
- RESP:
  - Hold valid, result, zero and err stable until rsp<owner>_ready is high at an edge.
  - On that edge: clear valid, set last_grant=owner, go to IDLE.
  - The non-owner rsp_valid stays 0.
- Latency and throughput: request accepted at edge E0, so rsp_valid is high after E0+2 edges. Peak throughput is one op per 3 cycles (rsp_ready held high).
- While in EXEC or RESP, both reqN_ready=0. New requests wait; requesters hold valid and payload stable until accepted.
- alu_* outputs hold their last latched values in IDLE; no glitching to 0.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1… starting with 0 after reset.
- Response-channel contents are held after valid drops. They are meaningful only while valid is high.
- rst_n asserted mid-operation (EXEC or RESP): the operation is discarded with no response, all regs take their reset values immediately, and last_grant=1.
- A request arriving in the same cycle as the final RESP handshake is not accepted until the following IDLE cycle.

Test Plan:
1. req0 ctrl=0010, op1=5, op2=7, rsp0_ready=1 -> req0_ready 1 cycle, rsp0_valid 2 cycles after accept, rsp0_result=12, zero=0, err=0.
2. req1 ctrl=0110, op1=op2=9 -> rsp1_result=0, rsp1_zero=1; rsp0_valid stays 0 throughout.
3. req0 and req1 both held valid for 4 ops, rsp*_ready=1 -> grant order 0,1,0,1, each response on the matching channel, 3 cycles per op.
4. req0 ctrl=1101, op1=0x8000_0000_0000_0000, op2=4, rsp0_ready low for 5 cycles -> rsp0_valid held, result 0xF800_0000_0000_0000 stable; req1 held valid sees req1_ready=0 until RESP completes.
5. req1 ctrl=1010 (illegal) -> rsp1_err=1, result=0, zero=1; the next legal op has err=0.
6. rst_n low during EXEC (asynchronous, mid-cycle) -> rsp*_valid=0 and alu_*=0 immediately with no response emitted; after release with both requesters valid, req0 is granted first.
